adder_arbiter: RTL and testbench
================================

# adder_arbiter

Round-robin scheduler sharing one combinational `adder` instance among NREQ requesters. It grants one requester per cycle, registers that requester's operands onto the shared adder inputs, captures the adder sum one cycle later, and returns it tagged with the requester index. It sits between requester blocks and the single `adder` (`q = {1'b0,a} + {1'b0,b}`) in the datapath.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: operand width; sum width is WIDTH+1.
- `IDW`, 2: requester-index width, equal to clog2(NREQ).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NREQ: request per requester; held high with stable operands until granted.
- `a_in` in NREQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
- `b_in` in NREQ*WIDTH: operand B, same packing.
- `gnt` out NREQ: registered one-hot grant, one-cycle pulse.
- `add_a` out WIDTH: registered operand to the shared adder `a`.
- `add_b` out WIDTH: registered operand to the shared adder `b`.
- `add_q` in WIDTH+1: shared adder result, combinational from `add_a`/`add_b`.
- `rsp_valid` out 1: response valid.
- `rsp_id` out IDW: index of the requester the response belongs to.
- `rsp_q` out WIDTH+1: captured sum.
- `rsp_ready` in 1: present only with `ADDER_ARB_STALL_EN`.

## Operation
- **Reset values:**
  - `gnt`=0, `add_a`=0, `add_b`=0, `rsp_valid`=0, `rsp_id`=0, `rsp_q`=0.
  - Internal `issue_valid`=0, `issue_id`=0.
  - Round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- **Eligibility:** `elig = req & ~gnt`. The requester granted in the current cycle is masked for one cycle because it is still dropping `req`. The same requester can therefore be granted at most every other cycle.
- **Arbitration:**
  - Search `elig` starting at index `last+1` (mod NREQ), in increasing index with wrap.
  - The first set bit wins.
  - On grant: `gnt[w]`<=1, `last`<=w, `add_a`<=a_in slice w, `add_b`<=b_in slice w, `issue_valid`<=1, `issue_id`<=w.
  - If `elig`==0: `gnt`<=0, `issue_valid`<=0, `add_a`/`add_b` hold, `last` holds.
- **Capture:** each cycle `rsp_valid`<=`issue_valid`. When `issue_valid`=1: `rsp_q`<=`add_q` and `rsp_id`<=`issue_id`. When `issue_valid`=0, `rsp_q`/`rsp_id` hold.
- **Arithmetic:** the sum is WIDTH+1 bits and carries the carry-out unchanged. The arbiter never truncates or extends it.
- **Reset mid-operation:** all issue and response state is cleared on the reset edge. In-flight operations are dropped with no response. Requesters must re-request.

## Timing
- Requester i raises `req` with operands before edge E0. If i wins at E0:
  - `gnt[i]`=1 and `add_a`/`add_b` are valid during cycle E0..E1.
  - `rsp_valid`=1 with the sum during cycle E1..E2.
- Grant-to-response latency: 1 cycle. Request-to-response latency: 2 edges minimum.
- Throughput: one operation per cycle when at least two requesters alternate.
- A requester must deassert `req` at the first edge after it sees `gnt[i]`=1, or it will be granted again.
- `gnt` is never asserted for more than one requester in the same cycle.

## Configuration
- `ADDER_ARB_STALL_EN` defined:
  - The `rsp_ready` port exists. Define `stall = rsp_valid & ~rsp_ready`.
  - While `stall`=1: `rsp_*` hold.
  - While `stall`=1 and `issue_valid`=1: issue registers hold, and `gnt`=0 with no new grant.
  - While `stall`=1 and `issue_valid`=0: one grant into the issue stage is permitted.
  - A response is consumed on an edge with `rsp_valid & rsp_ready`.
- `ADDER_ARB_STALL_EN` undefined:
  - No `rsp_ready` port. `rsp_valid` is a one-cycle pulse per operation and is never back-pressured.

## Test plan
- **Reset release:** `reset` high 2 cycles, then low with `req`=0. All outputs stay 0 and `rsp_valid` never rises.
- **Single request:** `req`=4'b0001, a=8'hFF, b=8'h01. Expect `gnt`=0001 for 1 cycle, `add_a`=FF, `add_b`=01; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_q`=9'h100.
- **Round-robin fairness:** all four `req` held high, operand pairs (i, i+1). Grant order is 0,1,2,3,0,... with one grant per cycle. Each `rsp_q`=2i+1 with matching `rsp_id`. The same requester is never granted on adjacent cycles.
- **Pointer wrap:** grant requester 3 alone, then `req`=4'b1001. The next grant is requester 0, not 3.
- **Mid-operation reset:** `reset` asserted in the cycle `gnt`=0010 is high. The next cycle shows `rsp_valid`=0, `gnt`=0, and `add_a`=`add_b`=0.
- **Stall (`ADDER_ARB_STALL_EN`):** `rsp_ready`=0 with three requesters pending.
  - The first response holds with `rsp_q` stable, the second sits in the issue stage, and no further `gnt` appears.
  - Then `rsp_ready`=1: responses drain in grant order and grants resume.

Source files
------------

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin scheduler sharing one combinational adder among NREQ requesters
//
// Purpose: grants one requester per cycle, registers its operands onto the
// shared adder inputs, captures the adder sum one cycle later and returns it
// tagged with the requester index.
//
// Optional feature macro: ADDER_ARB_STALL_EN (adds rsp_ready back-pressure).
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous, active-high
//   req        in   [NREQ]        per-requester request, held until granted
//   a_in, b_in in   [NREQ*WIDTH]  operands, requester i at [i*WIDTH +: WIDTH]
//   gnt        out  [NREQ]        registered one-hot grant pulse
//   add_a/b    out  [WIDTH]       registered operands to the shared adder
//   add_q      in   [WIDTH+1]     shared adder result (combinational)
//   rsp_valid  out                response valid
//   rsp_id     out  [IDW]         requester index of the response
//   rsp_q      out  [WIDTH+1]     captured sum
//   rsp_ready  in                 response accept (ADDER_ARB_STALL_EN only)
module adder_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  input  logic [WIDTH:0]          add_q,
  output logic                    rsp_valid,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH:0]          rsp_q
`ifdef ADDER_ARB_STALL_EN
  ,
  input  logic                    rsp_ready
`endif
);

  logic [IDW-1:0]   last;
  logic             issue_valid;
  logic [IDW-1:0]   issue_id;

  logic [NREQ-1:0]  elig;
  logic             found;
  logic [IDW-1:0]   win;
  logic [NREQ-1:0]  win_oh;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic             stall;
  logic             issue_hold;

  // The requester granted this cycle is still dropping req, so mask it.
  assign elig = req & ~gnt;

`ifdef ADDER_ARB_STALL_EN
  assign stall      = rsp_valid & ~rsp_ready;
  // A full issue stage behind a stalled response cannot advance.
  assign issue_hold = stall & issue_valid;
`else
  assign stall      = 1'b0;
  assign issue_hold = 1'b0;
`endif

  // Search elig starting just after the last winner, wrapping modulo NREQ.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    win    = '0;
    win_oh = '0;
    win_a  = '0;
    win_b  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && elig[idx]) begin
        found       = 1'b1;
        win         = IDW'(idx);
        win_oh[idx] = 1'b1;
        win_a       = a_in[idx*WIDTH +: WIDTH];
        win_b       = b_in[idx*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gnt         <= '0;
      add_a       <= '0;
      add_b       <= '0;
      last        <= IDW'(NREQ - 1);
      issue_valid <= 1'b0;
      issue_id    <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_q       <= '0;
    end else begin
      if (issue_hold) begin
        gnt <= '0;
      end else if (found) begin
        gnt         <= win_oh;
        last        <= win;
        add_a       <= win_a;
        add_b       <= win_b;
        issue_valid <= 1'b1;
        issue_id    <= win;
      end else begin
        gnt         <= '0;
        issue_valid <= 1'b0;
      end

      if (!stall) begin
        rsp_valid <= issue_valid;
        if (issue_valid) begin
          rsp_q  <= add_q;
          rsp_id <= issue_id;
        end
      end
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - directed self-checking bench for adder_arbiter
module tb_adder_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] a_in;
  logic [NREQ*WIDTH-1:0] b_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      add_a;
  logic [WIDTH-1:0]      add_b;
  logic [WIDTH:0]        add_q;
  logic                  rsp_valid;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH:0]        rsp_q;
`ifdef ADDER_ARB_STALL_EN
  logic                  rsp_ready;
`endif

  int n_tests;
  int n_fail;

  // Shared adder environment.
  assign add_q = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .gnt       (gnt),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_q     (add_q),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_q     (rsp_q)
`ifdef ADDER_ARB_STALL_EN
    ,
    .rsp_ready (rsp_ready)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [7:0] a, input logic [7:0] b);
    a_in[i*WIDTH +: WIDTH] = a;
    b_in[i*WIDTH +: WIDTH] = b;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b1;
    req     = '0;
    a_in    = '0;
    b_in    = '0;
`ifdef ADDER_ARB_STALL_EN
    rsp_ready = 1'b1;
`endif

    // Reset release
    tick();
    tick();
    reset = 1'b0;
    check("rst_gnt",   32'(gnt),       32'h0);
    check("rst_add_a", 32'(add_a),     32'h0);
    check("rst_add_b", 32'(add_b),     32'h0);
    check("rst_rspv",  32'(rsp_valid), 32'h0);
    check("rst_rspid", 32'(rsp_id),    32'h0);
    check("rst_rspq",  32'(rsp_q),     32'h0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("idle_rspv", 32'(rsp_valid), 32'h0);
      check("idle_gnt",  32'(gnt),       32'h0);
    end

    // Single request with carry-out
    set_ops(0, 8'hFF, 8'h01);
    req = 4'b0001;
    tick();
    check("single_gnt",   32'(gnt),       32'h1);
    check("single_add_a", 32'(add_a),     32'hFF);
    check("single_add_b", 32'(add_b),     32'h01);
    check("single_rspv0", 32'(rsp_valid), 32'h0);
    req = 4'b0000;
    tick();
    check("single_rspv",  32'(rsp_valid), 32'h1);
    check("single_rspid", 32'(rsp_id),    32'h0);
    check("single_rspq",  32'(rsp_q),     32'h100);
    check("single_gnt0",  32'(gnt),       32'h0);
    tick();
    check("single_pulse", 32'(rsp_valid), 32'h0);

    // Round-robin fairness from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_ops(i, 8'(i), 8'(i + 1));
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("rr_gnt",   32'(gnt),   32'(1 << (k % 4)));
      check("rr_add_a", 32'(add_a), 32'(k % 4));
      if (k > 0) begin
        check("rr_rspv",  32'(rsp_valid), 32'h1);
        check("rr_rspid", 32'(rsp_id),    32'((k - 1) % 4));
        check("rr_rspq",  32'(rsp_q),     32'(2 * ((k - 1) % 4) + 1));
      end
    end
    req = 4'b0000;
    tick();
    check("rr_gnt_end", 32'(gnt),    32'h0);
    check("rr_last_id", 32'(rsp_id), 32'h3);
    check("rr_last_q",  32'(rsp_q),  32'h7);
    tick();

    // Pointer wrap: after 3, requester 0 goes before 3
    req = 4'b1000;
    tick();
    check("wrap_g3", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    req = 4'b1001;
    tick();
    check("wrap_g0", 32'(gnt), 32'h1);
    req = 4'b1000;
    tick();
    check("wrap_g3b", 32'(gnt), 32'h8);
    req = 4'b0000;
    tick();
    // After 0 wins, requester 1 beats 0
    req = 4'b0001;
    tick();
    check("ptr_g0", 32'(gnt), 32'h1);
    req = 4'b0000;
    tick();
    req = 4'b0011;
    tick();
    check("ptr_g1", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    tick();

    // Carry through requester 1
    set_ops(1, 8'hC3, 8'h7E);
    req = 4'b0010;
    tick();
    check("c1_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();
    check("c1_rspv",  32'(rsp_valid), 32'h1);
    check("c1_rspid", 32'(rsp_id),    32'h1);
    check("c1_rspq",  32'(rsp_q),     32'h141);
    tick();

    // Mid-operation reset drops the in-flight op
    req = 4'b0010;
    tick();
    check("mr_gnt", 32'(gnt), 32'h2);
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    check("mr_rspv",  32'(rsp_valid), 32'h0);
    check("mr_gnt0",  32'(gnt),       32'h0);
    check("mr_add_a", 32'(add_a),     32'h0);
    check("mr_add_b", 32'(add_b),     32'h0);
    reset = 1'b0;
    tick();
    check("mr_rspv2", 32'(rsp_valid), 32'h0);

`ifdef ADDER_ARB_STALL_EN
    // Back-pressure with three requesters pending
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_ops(i, 8'(i * 16), 8'h01);
    rsp_ready = 1'b0;
    req = 4'b0111;
    tick();
    check("st_g0", 32'(gnt), 32'h1);
    req = req & ~gnt;
    tick();
    check("st_g1", 32'(gnt), 32'h2);
    req = req & ~gnt;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("st_hold_gnt",  32'(gnt),       32'h0);
      check("st_hold_rspv", 32'(rsp_valid), 32'h1);
      check("st_hold_id",   32'(rsp_id),    32'h0);
      check("st_hold_q",    32'(rsp_q),     32'h01);
    end
    rsp_ready = 1'b1;
    tick();
    check("st_g2",     32'(gnt),    32'h4);
    check("st_d1_id",  32'(rsp_id), 32'h1);
    check("st_d1_q",   32'(rsp_q),  32'h11);
    req = req & ~gnt;
    tick();
    check("st_d2_v",   32'(rsp_valid), 32'h1);
    check("st_d2_id",  32'(rsp_id),    32'h2);
    check("st_d2_q",   32'(rsp_q),     32'h21);
    tick();
    check("st_drained", 32'(rsp_valid), 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
